// File: rtl/conv_bank_loader.sv
`default_nettype none
// ============================================================================
// Module   : conv_bank_loader
// Brief    : Stream-to-memory loader: image memory first, then NUM_KER kernel
//            memories in sequential or interleaved order.
// Revision : 1.0
// ============================================================================
module conv_bank_loader #(
    parameter int ADDR    = 16,
    parameter int WIDTH   = 8,
    parameter int NUM_KER = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               mode_i,
    input  logic [ADDR-1:0]    img_len_i,
    input  logic [ADDR-1:0]    ker_len_i,
    input  logic [WIDTH-1:0]   s_data_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    output logic [ADDR-1:0]    img_addr_o,
    output logic [WIDTH-1:0]   img_data_o,
    output logic               img_wr_o,
    output logic [ADDR-1:0]    ker_addr_o,
    output logic [WIDTH-1:0]   ker_data_o,
    output logic [NUM_KER-1:0] ker_wr_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int CW = (NUM_KER > 1) ? $clog2(NUM_KER) : 1;

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_LOAD_IMG = 2'd1;
    localparam logic [1:0] c_LOAD_KER = 2'd2;
    localparam logic [1:0] c_DONE     = 2'd3;

    localparam logic [CW-1:0]   c_LAST_CH  = CW'(NUM_KER - 1);
    localparam logic [CW-1:0]   c_CH_ONE   = CW'(1);
    localparam logic [ADDR-1:0] c_ADDR_ONE = ADDR'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_mode;
    logic [ADDR-1:0]    r_img_len;
    logic [ADDR-1:0]    r_ker_len;
    logic [ADDR-1:0]    r_addr;
    logic [ADDR-1:0]    w_addr_nxt;
    logic [CW-1:0]      r_ch;
    logic [CW-1:0]      w_ch_nxt;

    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               w_ready_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;

    logic               r_img_wr;
    logic [ADDR-1:0]    r_img_addr;
    logic [WIDTH-1:0]   r_img_data;
    logic [NUM_KER-1:0] r_ker_wr;
    logic [ADDR-1:0]    r_ker_addr;
    logic [WIDTH-1:0]   r_ker_data;

    logic               w_accept;
    logic               w_img_last;
    logic               w_ker_addr_last;
    logic               w_ch_last;
    logic               w_ker_end;
    logic               w_img_beat;
    logic               w_ker_beat;
    logic [NUM_KER-1:0] w_ker_sel;

    assign w_accept        = s_valid_i & r_ready;
    assign w_img_last      = (r_addr == (r_img_len - c_ADDR_ONE));
    assign w_ker_addr_last = (r_addr == (r_ker_len - c_ADDR_ONE));
    assign w_ch_last       = (r_ch == c_LAST_CH);
    // Both orders end on the same beat: last channel at the last address.
    assign w_ker_end       = w_ker_addr_last & w_ch_last;
    assign w_img_beat      = w_accept & (r_state == c_LOAD_IMG);
    assign w_ker_beat      = w_accept & (r_state == c_LOAD_KER);

    generate
        for (genvar i = 0; i < NUM_KER; i++) begin : g_ker_sel
            assign w_ker_sel[i] = (r_ch == CW'(i));
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (start_i) begin
                    if (img_len_i != '0) begin
                        w_state_nxt = c_LOAD_IMG;
                    end else if (ker_len_i != '0) begin
                        w_state_nxt = c_LOAD_KER;
                    end else begin
                        w_state_nxt = c_DONE;
                    end
                end
            end
            c_LOAD_IMG: begin
                if (w_accept && w_img_last) begin
                    w_state_nxt = (r_ker_len != '0) ? c_LOAD_KER : c_DONE;
                end
            end
            c_LOAD_KER: begin
                if (w_accept && w_ker_end) begin
                    w_state_nxt = c_DONE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode (registered below so outputs are glitch-free)
    // ------------------------------------------------------------------
    always_comb begin
        w_ready_nxt = (w_state_nxt == c_LOAD_IMG) || (w_state_nxt == c_LOAD_KER);
        w_busy_nxt  = w_ready_nxt;
        w_done_nxt  = (w_state_nxt == c_DONE);
        w_err_nxt   = start_i && (r_state != c_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Address / channel counters
    // ------------------------------------------------------------------
    always_comb begin
        w_addr_nxt = r_addr;
        w_ch_nxt   = r_ch;
        case (r_state)
            c_IDLE: begin
                if (start_i) begin
                    w_addr_nxt = '0;
                    w_ch_nxt   = '0;
                end
            end
            c_LOAD_IMG: begin
                if (w_accept) begin
                    w_addr_nxt = w_img_last ? '0 : (r_addr + c_ADDR_ONE);
                end
            end
            c_LOAD_KER: begin
                if (w_accept) begin
                    if (r_mode) begin
                        // Interleaved: channel is the fast index.
                        if (w_ch_last) begin
                            w_ch_nxt   = '0;
                            w_addr_nxt = r_addr + c_ADDR_ONE;
                        end else begin
                            w_ch_nxt = r_ch + c_CH_ONE;
                        end
                    end else begin
                        if (w_ker_addr_last) begin
                            w_addr_nxt = '0;
                            w_ch_nxt   = w_ch_last ? '0 : (r_ch + c_CH_ONE);
                        end else begin
                            w_addr_nxt = r_addr + c_ADDR_ONE;
                        end
                    end
                end
            end
            default: begin
                w_addr_nxt = r_addr;
                w_ch_nxt   = r_ch;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_ch      <= '0;
            r_mode    <= 1'b0;
            r_img_len <= '0;
            r_ker_len <= '0;
        end else begin
            r_addr <= w_addr_nxt;
            r_ch   <= w_ch_nxt;
            if ((r_state == c_IDLE) && start_i) begin
                r_mode    <= mode_i;
                r_img_len <= img_len_i;
                r_ker_len <= ker_len_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory write ports: enables last one cycle, address/data hold
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_img_wr   <= 1'b0;
            r_img_addr <= '0;
            r_img_data <= '0;
            r_ker_wr   <= '0;
            r_ker_addr <= '0;
            r_ker_data <= '0;
        end else begin
            r_img_wr <= w_img_beat;
            r_ker_wr <= w_ker_beat ? w_ker_sel : '0;
            if (w_img_beat) begin
                r_img_addr <= r_addr;
                r_img_data <= s_data_i;
            end
            if (w_ker_beat) begin
                r_ker_addr <= r_addr;
                r_ker_data <= s_data_i;
            end
        end
    end

    assign s_ready_o  = r_ready;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign img_wr_o   = r_img_wr;
    assign img_addr_o = r_img_addr;
    assign img_data_o = r_img_data;
    assign ker_wr_o   = r_ker_wr;
    assign ker_addr_o = r_ker_addr;
    assign ker_data_o = r_ker_data;

endmodule
`default_nettype wire

// File: tb/tb_conv_bank_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_bank_loader
// Brief    : Three loaders (NUM_KER = 4, 3, 1) on one stream, checked against
//            a beat-plan reference model every cycle.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_conv_bank_loader;

    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, mode, valid;
    logic [15:0] img_len, ker_len;
    logic [7:0]  sdata;

    logic [ND-1:0]       rdy, iwr, bsy, dn, er;
    logic [ND-1:0][15:0] iad, kad;
    logic [ND-1:0][7:0]  idt, kdt;
    logic [3:0]          kwr0;
    logic [2:0]          kwr1;
    logic [0:0]          kwr2;

    conv_bank_loader #(.ADDR(16), .WIDTH(8), .NUM_KER(4)) u_dut0 (
        .clk(clk), .rst(rst), .start_i(start), .mode_i(mode),
        .img_len_i(img_len), .ker_len_i(ker_len), .s_data_i(sdata), .s_valid_i(valid),
        .s_ready_o(rdy[0]), .img_addr_o(iad[0]), .img_data_o(idt[0]), .img_wr_o(iwr[0]),
        .ker_addr_o(kad[0]), .ker_data_o(kdt[0]), .ker_wr_o(kwr0),
        .busy_o(bsy[0]), .done_o(dn[0]), .err_o(er[0]));

    conv_bank_loader #(.ADDR(16), .WIDTH(8), .NUM_KER(3)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start), .mode_i(mode),
        .img_len_i(img_len), .ker_len_i(ker_len), .s_data_i(sdata), .s_valid_i(valid),
        .s_ready_o(rdy[1]), .img_addr_o(iad[1]), .img_data_o(idt[1]), .img_wr_o(iwr[1]),
        .ker_addr_o(kad[1]), .ker_data_o(kdt[1]), .ker_wr_o(kwr1),
        .busy_o(bsy[1]), .done_o(dn[1]), .err_o(er[1]));

    conv_bank_loader #(.ADDR(16), .WIDTH(8), .NUM_KER(1)) u_dut2 (
        .clk(clk), .rst(rst), .start_i(start), .mode_i(mode),
        .img_len_i(img_len), .ker_len_i(ker_len), .s_data_i(sdata), .s_valid_i(valid),
        .s_ready_o(rdy[2]), .img_addr_o(iad[2]), .img_data_o(idt[2]), .img_wr_o(iwr[2]),
        .ker_addr_o(kad[2]), .ker_data_o(kdt[2]), .ker_wr_o(kwr2),
        .busy_o(bsy[2]), .done_o(dn[2]), .err_o(er[2]));

    function automatic int nk(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 3 : 1);
    endfunction

    function automatic logic [3:0] kwr(input int d);
        if (d == 0) return kwr0;
        if (d == 1) return {1'b0, kwr1};
        return {3'b000, kwr2};
    endfunction

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, d, $time, act, exp);
        end
    endtask

    // Reference model: each load is a list of beat targets (-1 = image)
    bit         m_busy [ND];
    bit         m_done [ND];
    bit         m_err  [ND];
    bit         m_iwr  [ND];
    logic [3:0] m_kwr  [ND];
    logic [15:0] m_iad [ND];
    logic [15:0] m_kad [ND];
    logic [7:0] m_idt  [ND];
    logic [7:0] m_kdt  [ND];
    int         m_k    [ND];
    int         m_T    [ND];
    int         p_ch   [ND][128];
    int         p_ad   [ND][128];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] img_mem [64];
    logic [7:0] kmem    [4][64];
    int done_cnt0 = 0, err_cnt0 = 0, wr_cnt0 = 0, done_cyc0 = 0;

    initial begin
        for (int d = 0; d < ND; d++) begin
            m_busy[d] = 0; m_done[d] = 0; m_err[d] = 0; m_iwr[d] = 0; m_kwr[d] = '0;
            m_iad[d] = '0; m_kad[d] = '0; m_idt[d] = '0; m_kdt[d] = '0;
            m_k[d] = 0; m_T[d] = 0;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            check("s_ready", d, rdy[d], m_busy[d]);
            check("busy", d, bsy[d], m_busy[d]);
            check("done", d, dn[d], m_done[d]);
            check("err", d, er[d], m_err[d]);
            check("img_wr", d, iwr[d], m_iwr[d]);
            check("ker_wr", d, kwr(d), m_kwr[d]);
            check("img_addr", d, iad[d], m_iad[d]);
            check("img_data", d, idt[d], m_idt[d]);
            check("ker_addr", d, kad[d], m_kad[d]);
            check("ker_data", d, kdt[d], m_kdt[d]);
        end
        if (iwr[0] === 1'b1) img_mem[iad[0][5:0]] = idt[0];
        for (int c = 0; c < 4; c++)
            if (kwr0[c] === 1'b1) kmem[c][kad[0][5:0]] = kdt[0];
        if (iwr[0] === 1'b1 || kwr0 != 4'b0) wr_cnt0++;
        if (dn[0] === 1'b1) begin done_cnt0++; done_cyc0 = cyc; end
        if (er[0] === 1'b1) err_cnt0++;

        // Predict outputs for the next cycle from the inputs sampled at the coming edge
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                m_busy[d] = 0; m_done[d] = 0; m_err[d] = 0; m_iwr[d] = 0; m_kwr[d] = '0;
                m_iad[d] = '0; m_kad[d] = '0; m_idt[d] = '0; m_kdt[d] = '0; m_k[d] = 0;
            end else begin
                bit idle, ndone;
                idle = !m_busy[d] && !m_done[d];
                ndone = 0;
                m_err[d] = start && !idle;
                m_iwr[d] = 0;
                m_kwr[d] = '0;
                if (m_busy[d] && valid) begin
                    if (p_ch[d][m_k[d]] < 0) begin
                        m_iwr[d] = 1; m_iad[d] = 16'(p_ad[d][m_k[d]]); m_idt[d] = sdata;
                    end else begin
                        m_kwr[d] = 4'b0001 << p_ch[d][m_k[d]];
                        m_kad[d] = 16'(p_ad[d][m_k[d]]); m_kdt[d] = sdata;
                    end
                    m_k[d]++;
                    if (m_k[d] == m_T[d]) begin m_busy[d] = 0; ndone = 1; end
                end else if (idle && start) begin
                    int il, kl, n;
                    il = int'(img_len); kl = int'(ker_len); n = nk(d);
                    for (int j = 0; j < il; j++) begin p_ch[d][j] = -1; p_ad[d][j] = j; end
                    for (int j = 0; j < n * kl; j++) begin
                        p_ch[d][il + j] = mode ? (j % n) : (j / kl);
                        p_ad[d][il + j] = mode ? (j / n) : (j % kl);
                    end
                    m_T[d] = il + n * kl;
                    m_k[d] = 0;
                    if (m_T[d] == 0) ndone = 1; else m_busy[d] = 1;
                end
                m_done[d] = ndone;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit all_idle();
        for (int d = 0; d < ND; d++) if (m_busy[d] || m_done[d]) return 0;
        return 1;
    endfunction

    function automatic bit all_busy();
        for (int d = 0; d < ND; d++) if (!m_busy[d]) return 0;
        return 1;
    endfunction

    int t0;

    // vmode: 0 = continuous valid, 1 = alternating 1-0-1, 2 = random
    task automatic run_load(input bit md, input int il, input int kl, input int vmode,
                            input bit incr, input bit err_inj);
        int n;
        mode = md; img_len = 16'(il); ker_len = 16'(kl); start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        mode = 1'($urandom);
        img_len = 16'($urandom_range(0, 8));
        ker_len = 16'($urandom_range(0, 6));
        n = 0;
        while (!all_idle() && n < 400) begin
            case (vmode)
                0: valid = 1'b1;
                1: valid = (n % 2 == 0);
                default: valid = ($urandom_range(0, 99) < 70);
            endcase
            sdata = incr ? 8'(8'h10 + n) : 8'($urandom);
            start = (err_inj && n == 3 && all_busy());
            tick();
            n++;
        end
        start = 1'b0;
        valid = 1'b0;
        if (n >= 400) check("load_timeout", 0, 1, 0);
    endtask

    int dbase, ebase, wbase;

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; valid = 1'b0;
        img_len = '0; ker_len = '0; sdata = '0;
        repeat (3) tick();
        check("reset_ready", 0, rdy[0], 0);
        check("reset_ker_wr", 0, kwr0, 0);
        rst = 1'b0;
        tick();

        // Sequential, NUM_KER=4: image 0x10..0x12, kernels 0x13..0x1A
        dbase = done_cnt0;
        run_load(1'b0, 3, 2, 0, 1'b1, 1'b0);
        check("seq_done_count", 0, done_cnt0 - dbase, 1);
        check("seq_done_latency", 0, done_cyc0 - t0, 12);
        for (int a = 0; a < 3; a++) check("seq_img_mem", 0, img_mem[a], 8'h10 + a);
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 2; a++)
                check("seq_ker_mem", 0, kmem[c][a], 8'h13 + 2 * c + a);

        // Interleaved: ker c, addr a receives 0x13 + c + 4a
        run_load(1'b1, 3, 2, 0, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 2; a++)
                check("ilv_ker_mem", 0, kmem[c][a], 8'h13 + c + 4 * a);

        // Zero lengths: done, no writes
        dbase = done_cnt0; wbase = wr_cnt0;
        run_load(1'b0, 0, 0, 0, 1'b1, 1'b0);
        check("zero_done_count", 0, done_cnt0 - dbase, 1);
        check("zero_writes", 0, wr_cnt0 - wbase, 0);

        // Kernel-only with toggling valid: exactly NUM_KER writes
        wbase = wr_cnt0;
        run_load(1'b0, 0, 1, 1, 1'b1, 1'b0);
        check("konly_writes", 0, wr_cnt0 - wbase, 4);

        // Start while busy: single error pulse, load still completes
        dbase = done_cnt0; ebase = err_cnt0;
        run_load(1'b0, 2, 3, 0, 1'b1, 1'b1);
        check("busy_start_err", 0, err_cnt0 - ebase, 1);
        check("busy_start_done", 0, done_cnt0 - dbase, 1);

        // Reset after 2 of 5 image beats
        mode = 1'b0; img_len = 16'd5; ker_len = 16'd1; start = 1'b1;
        tick();
        start = 1'b0; valid = 1'b1; sdata = 8'hA0;
        tick();
        sdata = 8'hA1;
        tick();
        rst = 1'b1; valid = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_ready", 0, rdy[0], 0);
        check("rst_busy", 0, bsy[0], 0);
        check("rst_img_addr", 0, iad[0], 0);
        check("rst_img_data", 0, idt[0], 0);
        check("rst_done", 0, dn[0], 0);
        dbase = done_cnt0;
        run_load(1'b0, 5, 1, 0, 1'b1, 1'b0);
        check("reload_img0", 0, img_mem[0], 8'h10);
        check("reload_done", 0, done_cnt0 - dbase, 1);

        // Parameter sweep: ker_len=5 in both modes on all three channel counts
        run_load(1'b0, 3, 5, 2, 1'b0, 1'b0);
        run_load(1'b1, 3, 5, 2, 1'b0, 1'b0);

        // Random loads
        for (int t = 0; t < 24; t++)
            run_load(1'($urandom), $urandom_range(0, 8), $urandom_range(0, 6),
                     $urandom_range(0, 2), 1'b0, 1'($urandom));

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
